// File: rtl/aec_pkg.sv
// Shared types and constants for the AEC character-interface transmitter.
// Pure declarations; no logic, no latency.
package aec_pkg;

    localparam int RES_W = 7;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        FIRST  = 3'd1,
        STREAM = 3'd2,
        WAIT   = 3'd3,
        FIN    = 3'd4
    } state_t;

    localparam logic [7:0] ASC_0     = 8'h30;
    localparam logic [7:0] ASC_1     = 8'h31;
    localparam logic [7:0] ASC_2     = 8'h32;
    localparam logic [7:0] ASC_3     = 8'h33;
    localparam logic [7:0] ASC_4     = 8'h34;
    localparam logic [7:0] ASC_5     = 8'h35;
    localparam logic [7:0] ASC_6     = 8'h36;
    localparam logic [7:0] ASC_7     = 8'h37;
    localparam logic [7:0] ASC_8     = 8'h38;
    localparam logic [7:0] ASC_9     = 8'h39;
    localparam logic [7:0] ASC_PLUS  = 8'h2B;
    localparam logic [7:0] ASC_MINUS = 8'h2D;
    localparam logic [7:0] ASC_MUL   = 8'h2A;
    localparam logic [7:0] ASC_LPAR  = 8'h28;
    localparam logic [7:0] ASC_RPAR  = 8'h29;
    localparam logic [7:0] ASC_EQ    = 8'h3D;

    function automatic logic [7:0] asc_digit(input logic [3:0] d);
        return ASC_0 + {4'h0, d};
    endfunction

endpackage

// File: rtl/aec_expr_tx_if.sv
// Character link between the transmitter (master) and an AEC (slave).
// Unclocked bundle; ready marks the first character, valid/result return the answer.
interface aec_expr_tx_if
    import aec_pkg::*;
();
    logic             ready;
    logic [7:0]       ascii_in;
    logic             valid;
    logic [RES_W-1:0] result;

    modport master (output ready, ascii_in, input valid, result);
    modport slave  (input ready, ascii_in, output valid, result);
endinterface

// File: rtl/aec_char_buf.sv
// DEPTH x 8 expression buffer: append-only writes, sticky drop flag, combinational read.
// Write takes effect next cycle; writes while full are dropped and set ovf.
module aec_char_buf #(
    parameter int DEPTH = 32,
    parameter int AW    = $clog2(DEPTH),
    parameter int LEN_W = AW + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr_en,
    input  logic [7:0]       wr_dat,
    input  logic             clr,
    input  logic [AW-1:0]    rd_idx,
    output logic [7:0]       rd_dat,
    output logic [LEN_W-1:0] len,
    output logic             ovf
);

    logic [7:0] mem [DEPTH];
    logic       full;

    assign full   = (len == LEN_W'(DEPTH));
    assign rd_dat = mem[rd_idx];

    // Storage is not reset: contents beyond len are never read.
    always_ff @(posedge clk) begin
        if (wr_en && !full && !clr) begin
            mem[len[AW-1:0]] <= wr_dat;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            len <= '0;
            ovf <= 1'b0;
        end else if (clr) begin
            len <= '0;
            ovf <= 1'b0;
        end else if (wr_en) begin
            if (full) begin
                ovf <= 1'b1;
            end else begin
                len <= len + LEN_W'(1);
            end
        end
    end

endmodule

// File: rtl/aec_expr_tx.sv
// Streams a loaded ASCII expression to an AEC and checks its answer; index k is driven k+1 edges after start.
// All outputs registered; optional AEC_TX_TIMEOUT_EN bounds the wait for valid.
module aec_expr_tx
    import aec_pkg::*;
#(
    parameter int DEPTH = 32,
    parameter int AW    = $clog2(DEPTH),
    parameter int LEN_W = AW + 1
`ifdef AEC_TX_TIMEOUT_EN
    ,
    parameter int TMO_CYCLES = 4096
`endif
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load_en,
    input  logic [7:0]       load_char,
    input  logic             load_clr,
    input  logic             start,
    input  logic [RES_W-1:0] exp_ans,
    output logic             busy,
    output logic             overflow,
    output logic             done,
    output logic             pass,
    output logic [RES_W-1:0] rx_result,
`ifdef AEC_TX_TIMEOUT_EN
    output logic             timeout,
`endif
    aec_expr_tx_if.master    aec
);

    state_t           state, state_nx;
    logic [LEN_W-1:0] len;
    logic [LEN_W-1:0] idx, idx_nx;
    logic [7:0]       rd_dat;
    logic [AW-1:0]    rd_idx;
    logic             in_idle, accept, sent_all, tmo_hit;

    logic             ready_q, ready_nx;
    logic [7:0]       ascii_q, ascii_nx;
    logic             busy_nx, done_nx, pass_nx;
    logic [RES_W-1:0] rx_nx, exp_q, exp_nx;

    assign in_idle  = (state == IDLE);
    assign accept   = in_idle && start && (len != '0);
    assign sent_all = (idx == len);
    assign rd_idx   = in_idle ? '0 : idx[AW-1:0];

    assign aec.ready    = ready_q;
    assign aec.ascii_in = ascii_q;

    aec_char_buf #(
        .DEPTH (DEPTH),
        .AW    (AW),
        .LEN_W (LEN_W)
    ) u_buf (
        .clk    (clk),
        .rst_n  (rst_n),
        .wr_en  (load_en && in_idle && !load_clr),
        .wr_dat (load_char),
        .clr    (load_clr && in_idle),
        .rd_idx (rd_idx),
        .rd_dat (rd_dat),
        .len    (len),
        .ovf    (overflow)
    );

`ifdef AEC_TX_TIMEOUT_EN
    localparam int TW = $clog2(TMO_CYCLES + 1);
    logic [TW-1:0] tmo_cnt;

    assign tmo_hit = (state == WAIT) && !aec.valid && (tmo_cnt == TW'(TMO_CYCLES - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tmo_cnt <= '0;
            timeout <= 1'b0;
        end else begin
            tmo_cnt <= (state == WAIT && state_nx == WAIT) ? tmo_cnt + TW'(1) : '0;
            if (accept) begin
                timeout <= 1'b0;
            end else if (tmo_hit) begin
                timeout <= 1'b1;
            end
        end
    end
`else
    assign tmo_hit = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:          if (accept) state_nx = FIRST;
            FIRST, STREAM: begin
                if (aec.valid)     state_nx = FIN;
                else if (sent_all) state_nx = WAIT;
                else               state_nx = STREAM;
            end
            WAIT:          if (aec.valid || tmo_hit) state_nx = FIN;
            FIN:           state_nx = IDLE;
            default:       state_nx = IDLE;
        endcase
    end

    // Next values of the registered outputs; ascii holds whenever nothing new is sent.
    always_comb begin
        ready_nx = 1'b0;
        ascii_nx = ascii_q;
        busy_nx  = (state_nx == FIRST) || (state_nx == STREAM) || (state_nx == WAIT);
        done_nx  = (state_nx == FIN);
        pass_nx  = pass;
        rx_nx    = rx_result;
        idx_nx   = idx;
        exp_nx   = exp_q;
        case (state)
            IDLE: begin
                if (accept) begin
                    exp_nx   = exp_ans;
                    pass_nx  = 1'b0;
                    rx_nx    = '0;
                    ready_nx = 1'b1;
                    ascii_nx = rd_dat;
                    idx_nx   = LEN_W'(1);
                end
            end
            FIRST, STREAM, WAIT: begin
                if (aec.valid) begin
                    rx_nx   = aec.result;
                    pass_nx = (aec.result == exp_q);
                end else if (tmo_hit) begin
                    rx_nx   = '0;
                    pass_nx = 1'b0;
                end else if (state != WAIT && !sent_all) begin
                    ascii_nx = rd_dat;
                    idx_nx   = idx + LEN_W'(1);
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ready_q   <= 1'b0;
            ascii_q   <= 8'h00;
            busy      <= 1'b0;
            done      <= 1'b0;
            pass      <= 1'b0;
            rx_result <= '0;
            idx       <= '0;
            exp_q     <= '0;
        end else begin
            ready_q   <= ready_nx;
            ascii_q   <= ascii_nx;
            busy      <= busy_nx;
            done      <= done_nx;
            pass      <= pass_nx;
            rx_result <= rx_nx;
            idx       <= idx_nx;
            exp_q     <= exp_nx;
        end
    end

endmodule

// File: tb/tb_aec_expr_tx.sv
// Randomized scoreboard bench: the expected busy-cycle character trace and verdict are queued
// per transaction and compared by an independent monitor when done pulses.
module tb_aec_expr_tx;
    import aec_pkg::*;

    localparam int DEPTH = 32;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             load_en = 1'b0;
    logic [7:0]       load_char = 8'h00;
    logic             load_clr = 1'b0;
    logic             start = 1'b0;
    logic [RES_W-1:0] exp_ans = '0;
    logic             busy, overflow, done, pass;
    logic [RES_W-1:0] rx_result;
`ifdef AEC_TX_TIMEOUT_EN
    logic             timeout;
`endif

    aec_expr_tx_if aec ();

    aec_expr_tx #(.DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .load_en   (load_en),
        .load_char (load_char),
        .load_clr  (load_clr),
        .start     (start),
        .exp_ans   (exp_ans),
        .busy      (busy),
        .overflow  (overflow),
        .done      (done),
        .pass      (pass),
        .rx_result (rx_result),
`ifdef AEC_TX_TIMEOUT_EN
        .timeout   (timeout),
`endif
        .aec       (aec)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Reference state: what the buffer should hold, and pending expectations.
    string            mbuf = "";
    bit               movf = 1'b0;
    string            sb_chars[$];
    bit               sb_pass[$];
    logic [RES_W-1:0] sb_rx[$];

    byte unsigned     lg[$];
    bit               rq[$];

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // Monitor: log every busy cycle, judge the trace when done pulses.
    always @(negedge clk) begin
        if (!rst_n) begin
            lg.delete();
            rq.delete();
        end else begin
            if (busy) begin
                lg.push_back(aec.ascii_in);
                rq.push_back(aec.ready);
            end
            if (done) begin
                if (sb_chars.size() == 0) begin
                    chk("done_unexpected", int'(done), 0);
                end else begin
                    string            ec;
                    bit               ep;
                    logic [RES_W-1:0] er;
                    ec = sb_chars.pop_front();
                    ep = sb_pass.pop_front();
                    er = sb_rx.pop_front();
                    chk("busy_cycles", lg.size(), ec.len());
                    for (int i = 0; i < lg.size() && i < ec.len(); i++) begin
                        chk($sformatf("ascii[%0d]", i), int'(lg[i]), int'(ec[i]));
                        chk($sformatf("ready[%0d]", i), int'(rq[i]), (i == 0) ? 1 : 0);
                    end
                    chk("pass", int'(pass), int'(ep));
                    chk("rx_result", int'(rx_result), int'(er));
                    chk("busy_at_done", int'(busy), 0);
                end
                lg.delete();
                rq.delete();
            end
        end
    end

    task automatic load_str(input string s);
        for (int i = 0; i < s.len(); i++) begin
            @(posedge clk); #1;
            load_en   = 1'b1;
            load_char = s[i];
            if (mbuf.len() < DEPTH) mbuf = {mbuf, s.substr(i, i)};
            else                    movf = 1'b1;
        end
        @(posedge clk); #1;
        load_en = 1'b0;
    endtask

    task automatic clr_buf();
        @(posedge clk); #1;
        load_clr = 1'b1;
        @(posedge clk); #1;
        load_clr = 1'b0;
        mbuf = "";
        movf = 1'b0;
    endtask

    // AEC responds with valid during busy cycle v (0 = the cycle carrying index 0).
    task automatic run_txn(input int v, input logic [RES_W-1:0] ea, input logic [RES_W-1:0] res);
        string ec;
        int    l;
        l  = mbuf.len();
        ec = "";
        for (int c = 0; c <= v; c++) begin
            int k;
            k  = (c < l) ? c : l - 1;
            ec = {ec, mbuf.substr(k, k)};
        end
        sb_chars.push_back(ec);
        sb_pass.push_back(res == ea);
        sb_rx.push_back(res);
        @(posedge clk); #1;
        start   = 1'b1;
        exp_ans = ea;
        @(posedge clk); #1;
        start = 1'b0;
        for (int c = 0; c <= v; c++) begin
            if (c == v) begin
                aec.valid  = 1'b1;
                aec.result = res;
            end
            @(posedge clk); #1;
        end
        aec.valid = 1'b0;
        @(negedge clk); #1;
        chk("done_seen", sb_chars.size(), 0);
        sb_chars.delete();
        sb_pass.delete();
        sb_rx.delete();
    endtask

    task automatic check_idle_outputs(input string tag);
        chk({tag, "_busy"}, int'(busy), 0);
        chk({tag, "_ready"}, int'(aec.ready), 0);
        chk({tag, "_ascii"}, int'(aec.ascii_in), 0);
        chk({tag, "_done"}, int'(done), 0);
        chk({tag, "_pass"}, int'(pass), 0);
        chk({tag, "_rx"}, int'(rx_result), 0);
        chk({tag, "_ovf"}, int'(overflow), 0);
`ifdef AEC_TX_TIMEOUT_EN
        chk({tag, "_timeout"}, int'(timeout), 0);
`endif
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        string alph;
        string s;
        alph       = "0123456789+-*()";
        aec.valid  = 1'b0;
        aec.result = '0;
        repeat (2) @(posedge clk);
        #1;
        check_idle_outputs("reset");
        rst_n = 1'b1;

        // "3+4=": answer three cycles after '=', then wrong expectation twice back-to-back.
        load_str("3+4=");
        run_txn(6, 7'd7, 7'd7);
        run_txn(6, 7'd8, 7'd7);
        run_txn(6, 7'd8, 7'd7);

        // Overflow: 33 loads keep 32 characters.
        clr_buf();
        s = "";
        for (int i = 0; i < DEPTH + 1; i++) s = $sformatf("%s%c", s, alph[i % 10]);
        load_str(s);
        chk("overflow_set", int'(overflow), int'(movf));
        run_txn(DEPTH + 1, 7'd5, 7'd5);
        clr_buf();
        chk("overflow_clr", int'(overflow), int'(movf));
        @(posedge clk); #1;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk("busy_empty_start", int'(busy), 0);
            @(posedge clk); #1;
        end

        // Early response while '*' is on the line.
        load_str("(2*5)=");
        run_txn(2, 7'd10, 7'd10);

        for (int t = 0; t < 25; t++) begin
            int               l, v;
            logic [RES_W-1:0] ea, res;
            if ($urandom_range(0, 3) != 0 || mbuf.len() == 0) begin
                clr_buf();
                l = ($urandom_range(0, 5) == 0) ? DEPTH : $urandom_range(1, 14);
                s = "";
                for (int i = 0; i < l - 1; i++) s = $sformatf("%s%c", s, alph[$urandom_range(0, 14)]);
                s = {s, "="};
                load_str(s);
            end
            l   = mbuf.len();
            v   = $urandom_range(0, l + 4);
            ea  = RES_W'($urandom_range(0, 127));
            res = ($urandom_range(0, 1) == 1) ? ea : RES_W'($urandom_range(0, 127));
            run_txn(v, ea, res);
        end

        // Reset while waiting for the answer.
        clr_buf();
        load_str("9=");
        @(posedge clk); #1;
        start   = 1'b1;
        exp_ans = 7'd9;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("busy_in_wait", int'(busy), 1);
        chk("ascii_in_wait", int'(aec.ascii_in), int'(ASC_EQ));
        rst_n = 1'b0;
        #1;
        check_idle_outputs("midrst");
        @(posedge clk); #1;
        rst_n = 1'b1;
        mbuf  = "";
        movf  = 1'b0;
        aec.valid  = 1'b1;
        aec.result = 7'd9;
        @(posedge clk); #1;
        aec.valid = 1'b0;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk("busy_after_rst", int'(busy), 0);
            chk("done_after_rst", int'(done), 0);
            @(posedge clk); #1;
        end

        chk("scoreboard_empty", sb_chars.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/aec_expr_tx.md
Name: aec_expr_tx

Overview:
Stimulus-side transmitter for the arithmetic-expression-calculator (AEC) character interface.
- A host loads an ASCII expression (digits, operators, parentheses, terminating '=') into an internal character buffer.
- On start, the block streams the buffer to an AEC over ready/ascii_in, one character per cycle.
- It then waits for the AEC's valid, captures result, and compares it against a host-supplied expected answer.
- Used in on-chip self-test and as a synthesizable replacement for file-driven stimulus.

Parameters:
DEPTH, 32, character buffer entries (power of two, 4..256)
AW, $clog2(DEPTH), buffer index width
LEN_W, AW+1, length-counter width (holds 0..DEPTH)

Ports:
clk  in  1  system clock, all logic on rising edge
rst_n  in  1  asynchronous active-low reset
load_en  in  1  append load_char to the buffer this cycle
load_char  in  8  ASCII character to append
load_clr  in  1  empty the buffer (length := 0, overflow := 0)
start  in  1  begin one transaction (single-cycle pulse)
exp_ans  in  7  expected AEC result, sampled on accepted start
busy  out  1  high from accepted start until done
overflow  out  1  sticky: a load was dropped because the buffer was full
ready  out  1  to AEC: first-character strobe
ascii_in  out  8  to AEC: character stream
valid  in  1  from AEC: result valid
result  in  7  from AEC: computed result
done  out  1  one-cycle pulse, transaction finished
pass  out  1  result == captured exp_ans; held until next start
rx_result  out  7  captured result; held until next start

Behaviour:
- Reset values: busy=0, overflow=0, ready=0, ascii_in=8'h00, done=0, pass=0, rx_result=0, length=0, state=IDLE. Buffer contents are don't-care.
- All outputs are registered.
- Load rules, IDLE only:
  - load_en writes buf[length], length+1.
  - load_en when length==DEPTH: write dropped, overflow set.
  - load_clr has priority over load_en in the same cycle.
  - load_en and load_clr are ignored outside IDLE.
- start is accepted only in IDLE with length>=1. start with length==0 is ignored (no busy, no done). On acceptance: capture exp_ans, clear pass and rx_result, idx:=0.
- FSM states: IDLE, FIRST, STREAM, WAIT, FIN.
  - IDLE -> FIRST on accepted start.
  - FIRST (one cycle): ready=1, ascii_in=buf[0], idx:=1. Next state is STREAM if length>1, else WAIT.
  - STREAM: ready=0, ascii_in=buf[idx], idx+1 each cycle. Go to WAIT after the cycle driving buf[length-1].
  - WAIT: ready=0, ascii_in holds the last character.
  - FIN (one cycle): done=1, then IDLE.
- Latency: the character at index k appears on ascii_in exactly k+1 cycles after the start-accept edge. ready is high only in the cycle carrying index 0.
- Result capture: valid sampled high in FIRST, STREAM or WAIT -> rx_result:=result, pass:=(result==exp_ans), next state FIN.
  - valid during FIRST/STREAM (early response) aborts the remaining characters. ascii_in holds its current value.
  - valid seen in IDLE or FIN is ignored.
- Buffer contents persist across transactions. Back-to-back start re-sends the same expression. Characters are not interpreted; the '=' terminator is the host's responsibility.
- busy=1 in FIRST, STREAM and WAIT. busy falls in the cycle done is asserted.
- Reset asserted mid-transaction returns everything to reset values immediately (asynchronous); the loaded expression is lost (length=0).

Optional Feature:
AEC_TX_TIMEOUT_EN
- With it: add parameter TMO_CYCLES (default 4096) and output timeout (1 bit, sticky until next accepted start).
  - A counter runs in WAIT only.
  - On reaching TMO_CYCLES without valid: timeout:=1, pass:=0, rx_result:=0, go to FIN (done pulses).
- Without it: WAIT is left only by valid or reset; the timeout port and counter do not exist.

Decomposition:
- Shared package aec_pkg:
  - state enum typedef (IDLE, FIRST, STREAM, WAIT, FIN)
  - ASCII constants for '0'..'9', '+', '-', '*', '(', ')', '='
  - result width constant RES_W=7
- One sub-module, aec_char_buf: DEPTH x 8 register array with write pointer/length, full flag and combinational read port. The FSM stays in aec_expr_tx.

Test Plan:
- Load "3+4=" (4 chars), exp_ans=7, start; AEC model returns valid/result=7 three cycles after '=' -> ready high only with '3'; ascii_in sequence '3','+','4','=' on consecutive cycles; done one pulse; pass=1; rx_result=7.
- Same buffer, exp_ans=8, result=7 -> pass=0, rx_result=7; second start immediately after done re-sends "3+4=" unchanged.
- Load 33 chars into DEPTH=32 -> length 32, overflow=1; load_clr -> overflow=0; start with empty buffer -> busy stays 0, no done.
- Load "(2*5)=", assert valid with result=10 while '*' is on ascii_in -> streaming stops, ascii_in holds '*', done next cycle, pass reflects exp_ans=10.
- Load "9=", start, pull rst_n low while in WAIT -> all outputs at reset values in the same cycle, length=0, later valid ignored.
- With AEC_TX_TIMEOUT_EN, TMO_CYCLES=16, never assert valid -> done 16 cycles after entering WAIT, timeout=1, pass=0.
